// File: rtl/i2c_seg_target.sv
// -----------------------------------------------------------------------------
// i2c_seg_target
// I2C target receiver that models the seven-segment driver on the ALU board
// display bus. SCL/SDA are oversampled with the system clock. Write transactions
// to DEV_ADDR are decoded as <addr+W> <pointer> <data>*, and the data bytes land
// in a small register file. Matching bytes are ACKed by pulling SDA low.
//
// Ports:
//   clk_i      system clock (100 MHz)
//   reset_ni   synchronous active-low reset
//   scl_i      SCL line level (asynchronous)
//   sda_i      SDA line level (asynchronous)
//   sda_oe_o   1 = pull SDA low (ACK), 0 = release
//   regs_o     register file contents, regs_o[i] is register i
//   wr_stb_o   one-cycle pulse when a data byte is committed
//   wr_addr_o  register index written, valid with wr_stb_o
//   busy_o     high from a detected START until the following STOP
// -----------------------------------------------------------------------------
module i2c_seg_target #(
    parameter logic [6:0] DEV_ADDR  = 7'h70,
    parameter int         NUM_REGS  = 4,
    parameter int         REG_WIDTH = 8
) (
    input  logic                                 clk_i,
    input  logic                                 reset_ni,
    input  logic                                 scl_i,
    input  logic                                 sda_i,
    output logic                                 sda_oe_o,
    output logic [NUM_REGS-1:0][REG_WIDTH-1:0]   regs_o,
    output logic                                 wr_stb_o,
    output logic [$clog2(NUM_REGS)-1:0]          wr_addr_o,
    output logic                                 busy_o
);

    localparam int PTR_W = $clog2(NUM_REGS);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_PTR_ACK, S_DATA, S_DATA_ACK, S_IGNORE
    } state_t;

    logic             r_scl_s1, r_scl_s2, r_scl_d;
    logic             r_sda_s1, r_sda_s2, r_sda_d;
    state_t           r_state, w_state_nx;
    logic [3:0]       r_bit_cnt, w_bit_cnt_nx;
    logic [6:0]       r_shift, w_shift_nx;
    logic [PTR_W-1:0] r_ptr, w_ptr_nx;
    logic             r_ack, w_ack_nx;
    logic             w_wr_en;

    logic             w_scl_rise, w_scl_fall, w_start, w_stop, w_last_bit;
    logic [7:0]       w_byte;

    // Bus events on the synchronized lines; START/STOP require SCL stably high
    // so a simultaneous SCL edge is never mistaken for one.
    assign w_scl_rise = r_scl_s2 & ~r_scl_d;
    assign w_scl_fall = ~r_scl_s2 & r_scl_d;
    assign w_start    = r_scl_s2 & r_scl_d & ~r_sda_s2 & r_sda_d;
    assign w_stop     = r_scl_s2 & r_scl_d & r_sda_s2 & ~r_sda_d;
    assign w_byte     = {r_shift, r_sda_s2};
    assign w_last_bit = w_scl_rise && (r_bit_cnt == 4'd7);

    // Two-stage synchronizers plus edge-detect history, preset to idle bus.
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            r_scl_s1 <= 1'b1; r_scl_s2 <= 1'b1; r_scl_d <= 1'b1;
            r_sda_s1 <= 1'b1; r_sda_s2 <= 1'b1; r_sda_d <= 1'b1;
        end else begin
            r_scl_s1 <= scl_i;    r_scl_s2 <= r_scl_s1; r_scl_d <= r_scl_s2;
            r_sda_s1 <= sda_i;    r_sda_s2 <= r_sda_s1; r_sda_d <= r_sda_s2;
        end
    end

    // Next-state logic: START/STOP override everything, otherwise per state.
    always_comb begin
        w_state_nx   = r_state;
        w_bit_cnt_nx = r_bit_cnt;
        w_shift_nx   = r_shift;
        w_ptr_nx     = r_ptr;
        w_ack_nx     = r_ack;
        w_wr_en      = 1'b0;
        if (w_start) begin
            w_state_nx   = S_ADDR;
            w_bit_cnt_nx = 4'd0;
            w_ack_nx     = 1'b0;
        end else if (w_stop) begin
            w_state_nx   = S_IDLE;
            w_bit_cnt_nx = 4'd0;
            w_ack_nx     = 1'b0;
        end else begin
            case (r_state)
                S_ADDR, S_PTR, S_DATA: begin
                    if (w_scl_rise) begin
                        w_shift_nx   = w_byte[6:0];
                        w_bit_cnt_nx = r_bit_cnt + 4'd1;
                    end else begin
                        w_shift_nx   = r_shift;
                    end
                    if (w_last_bit) begin
                        if (r_state == S_ADDR) begin
                            // Only a write to our address is accepted; reads are NACKed.
                            if ((w_byte[7:1] == DEV_ADDR) && !w_byte[0]) begin
                                w_state_nx = S_ADDR_ACK;
                            end else begin
                                w_state_nx = S_IGNORE;
                            end
                        end else if (r_state == S_PTR) begin
                            if ({24'd0, w_byte} < $unsigned(NUM_REGS)) begin
                                w_ptr_nx   = w_byte[PTR_W-1:0];
                                w_state_nx = S_PTR_ACK;
                            end else begin
                                w_state_nx = S_IGNORE;
                            end
                        end else begin
                            w_wr_en    = 1'b1;
                            w_ptr_nx   = (r_ptr == PTR_W'(NUM_REGS - 1)) ? '0 : r_ptr + 1'b1;
                            w_state_nx = S_DATA_ACK;
                        end
                    end else begin
                        w_state_nx = r_state;
                    end
                end
                S_ADDR_ACK, S_PTR_ACK, S_DATA_ACK: begin
                    // First SCL fall after bit 8 opens the ACK, the next one
                    // (end of the 9th clock) closes it and starts a new byte.
                    if (w_scl_fall) begin
                        if (!r_ack) begin
                            w_ack_nx = 1'b1;
                        end else begin
                            w_ack_nx     = 1'b0;
                            w_bit_cnt_nx = 4'd0;
                            w_state_nx   = (r_state == S_ADDR_ACK) ? S_PTR : S_DATA;
                        end
                    end else begin
                        w_ack_nx = r_ack;
                    end
                end
                S_IDLE, S_IGNORE: begin
                    w_state_nx = r_state;
                end
                default: begin
                    w_state_nx   = S_IDLE;
                    w_bit_cnt_nx = 4'd0;
                    w_ack_nx     = 1'b0;
                end
            endcase
        end
    end

    // FSM, datapath and registered outputs.
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            r_state   <= S_IDLE;
            r_bit_cnt <= 4'd0;
            r_shift   <= 7'd0;
            r_ptr     <= '0;
            r_ack     <= 1'b0;
            sda_oe_o  <= 1'b0;
            regs_o    <= '0;
            wr_stb_o  <= 1'b0;
            wr_addr_o <= '0;
            busy_o    <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_bit_cnt <= w_bit_cnt_nx;
            r_shift   <= w_shift_nx;
            r_ptr     <= w_ptr_nx;
            r_ack     <= w_ack_nx;
            sda_oe_o  <= r_ack;
            wr_stb_o  <= w_wr_en;
            if (w_wr_en) begin
                regs_o[r_ptr] <= w_byte;
                wr_addr_o     <= r_ptr;
            end
            if (w_start) begin
                busy_o <= 1'b1;
            end else if (w_stop) begin
                busy_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_i2c_seg_target.sv
// -----------------------------------------------------------------------------
// tb_i2c_seg_target
// Directed bench for i2c_seg_target: a bit-banged I2C master drives SCL/SDA
// (SDA is wired-AND with the target's pull-down) and results are checked
// against hand-computed values.
// -----------------------------------------------------------------------------
module tb_i2c_seg_target;

    logic             clk = 1'b0;
    logic             reset_ni;
    logic             scl_m;
    logic             sda_m;
    logic             sda_line;
    logic             sda_oe;
    logic [3:0][7:0]  regs;
    logic             wr_stb;
    logic [1:0]       wr_addr;
    logic             busy;

    int               n_checks = 0;
    int               n_errors = 0;

    // Monitor state (written only by the monitor process).
    int               stb_cnt    = 0;
    int               stb_double = 0;
    int               oe_rises   = 0;
    logic             stb_prev   = 1'b0;
    logic             oe_prev    = 1'b0;
    logic [1:0]       stb_log [0:63];

    always #5 clk = ~clk;

    assign sda_line = sda_m & ~sda_oe;

    i2c_seg_target #(
        .DEV_ADDR (7'h70),
        .NUM_REGS (4),
        .REG_WIDTH(8)
    ) dut (
        .clk_i    (clk),
        .reset_ni (reset_ni),
        .scl_i    (scl_m),
        .sda_i    (sda_line),
        .sda_oe_o (sda_oe),
        .regs_o   (regs),
        .wr_stb_o (wr_stb),
        .wr_addr_o(wr_addr),
        .busy_o   (busy)
    );

    // Record write strobes, strobe width violations and ACK assertions.
    always @(posedge clk) begin
        stb_prev <= wr_stb;
        oe_prev  <= sda_oe;
        if (wr_stb) begin
            stb_log[stb_cnt % 64] <= wr_addr;
            stb_cnt <= stb_cnt + 1;
        end
        if (wr_stb && stb_prev) stb_double <= stb_double + 1;
        if (sda_oe && !oe_prev) oe_rises <= oe_rises + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; wait_clk(10);
        scl_m = 1'b1; wait_clk(20);
        sda_m = 1'b0; wait_clk(20);
        scl_m = 1'b0; wait_clk(10);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; wait_clk(10);
        scl_m = 1'b1; wait_clk(20);
        sda_m = 1'b1; wait_clk(20);
    endtask

    task automatic send_bit(input logic b);
        sda_m = b;    wait_clk(10);
        scl_m = 1'b1; wait_clk(20);
        scl_m = 1'b0; wait_clk(10);
    endtask

    // Eight data bits then the 9th clock; ack = target pulled SDA low mid-high.
    task automatic send_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        sda_m = 1'b1; wait_clk(10);
        scl_m = 1'b1; wait_clk(10);
        ack = ~sda_line;
        wait_clk(10);
        scl_m = 1'b0; wait_clk(10);
    endtask

    initial begin
        logic a0, a1, a2, a3;
        int   s0, o0;

        reset_ni = 1'b0; scl_m = 1'b1; sda_m = 1'b1;
        wait_clk(5);
        check_eq("rst_sda_oe",  {31'd0, sda_oe}, 32'd0);
        check_eq("rst_regs",    regs,            32'h0000_0000);
        check_eq("rst_wr_stb",  {31'd0, wr_stb}, 32'd0);
        check_eq("rst_wr_addr", {30'd0, wr_addr}, 32'd0);
        check_eq("rst_busy",    {31'd0, busy},   32'd0);
        reset_ni = 1'b1;
        wait_clk(5);

        // Basic write: E0 / 01 / 3F / 06.
        s0 = stb_cnt;
        i2c_start();
        check_eq("t1_busy_hi", {31'd0, busy}, 32'd1);
        send_byte(8'hE0, a0);
        send_byte(8'h01, a1);
        send_byte(8'h3F, a2);
        send_byte(8'h06, a3);
        check_eq("t1_acks", {28'd0, a0, a1, a2, a3}, 32'hF);
        i2c_stop();
        check_eq("t1_regs",    regs, 32'h0006_3F00);
        check_eq("t1_stb_cnt", stb_cnt - s0, 32'd2);
        check_eq("t1_addr0",   {30'd0, stb_log[s0 % 64]},       32'd1);
        check_eq("t1_addr1",   {30'd0, stb_log[(s0 + 1) % 64]}, 32'd2);
        check_eq("t1_busy_lo", {31'd0, busy}, 32'd0);

        // Wrong address: no ACK, no write.
        s0 = stb_cnt; o0 = oe_rises;
        i2c_start();
        send_byte(8'hE4, a0);
        send_byte(8'h55, a1);
        i2c_stop();
        check_eq("t2_acks",    {30'd0, a0, a1}, 32'd0);
        check_eq("t2_oe_cnt",  oe_rises - o0,  32'd0);
        check_eq("t2_stb_cnt", stb_cnt - s0,   32'd0);
        check_eq("t2_regs",    regs, 32'h0006_3F00);

        // Read request NACKed, then recovery on a repeated START.
        s0 = stb_cnt;
        i2c_start();
        send_byte(8'hE1, a0);
        send_byte(8'h12, a1);
        check_eq("t3_nack",   {30'd0, a0, a1}, 32'd0);
        check_eq("t3_no_stb", stb_cnt - s0, 32'd0);
        i2c_start();
        send_byte(8'hE0, a0);
        send_byte(8'h00, a1);
        send_byte(8'h5A, a2);
        i2c_stop();
        check_eq("t3_acks", {29'd0, a0, a1, a2}, 32'h7);
        check_eq("t3_regs", regs, 32'h0006_3F5A);

        // Pointer wrap from 3 to 0.
        s0 = stb_cnt;
        i2c_start();
        send_byte(8'hE0, a0);
        send_byte(8'h03, a1);
        send_byte(8'h11, a2);
        send_byte(8'h22, a3);
        send_byte(8'h33, a3);
        i2c_stop();
        check_eq("t4_regs",  regs, 32'h1106_3322);
        check_eq("t4_addrs", {26'd0, stb_log[s0 % 64], stb_log[(s0 + 1) % 64], stb_log[(s0 + 2) % 64]},
                 {26'd0, 2'd3, 2'd0, 2'd1});

        // Out-of-range pointer: NACK, nothing written.
        s0 = stb_cnt;
        i2c_start();
        send_byte(8'hE0, a0);
        send_byte(8'h07, a1);
        send_byte(8'h99, a2);
        i2c_stop();
        check_eq("t5_acks",    {29'd0, a0, a1, a2}, 32'h4);
        check_eq("t5_stb_cnt", stb_cnt - s0, 32'd0);
        check_eq("t5_regs",    regs, 32'h1106_3322);

        // Repeated START after 4 data bits discards the partial byte.
        s0 = stb_cnt;
        i2c_start();
        send_byte(8'hE0, a0);
        send_byte(8'h00, a1);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        i2c_start();
        send_byte(8'hE0, a0);
        send_byte(8'h00, a1);
        send_byte(8'hAA, a2);
        i2c_stop();
        check_eq("t6_stb_cnt", stb_cnt - s0, 32'd1);
        check_eq("t6_regs",    regs, 32'h1106_33AA);

        // Reset pulse during a DATA_ACK phase.
        i2c_start();
        send_byte(8'hE0, a0);
        send_byte(8'h02, a1);
        for (int i = 7; i >= 0; i--) send_bit(1'b1);
        sda_m = 1'b1; wait_clk(10);
        scl_m = 1'b1; wait_clk(5);
        check_eq("t7_ack_before_rst", {31'd0, sda_oe}, 32'd1);
        reset_ni = 1'b0;
        wait_clk(1);
        check_eq("t7_rst_oe",   {31'd0, sda_oe}, 32'd0);
        check_eq("t7_rst_regs", regs,            32'h0000_0000);
        check_eq("t7_rst_busy", {31'd0, busy},   32'd0);
        wait_clk(2);
        reset_ni = 1'b1;
        wait_clk(13);
        scl_m = 1'b0; wait_clk(10);
        // Without a fresh START the target must ignore the bus.
        s0 = stb_cnt;
        send_byte(8'hE0, a0);
        send_byte(8'h00, a1);
        send_byte(8'h44, a2);
        i2c_stop();
        check_eq("t7_idle_nack", {29'd0, a0, a1, a2}, 32'd0);
        check_eq("t7_idle_stb",  stb_cnt - s0, 32'd0);
        i2c_start();
        send_byte(8'hE0, a0);
        send_byte(8'h00, a1);
        send_byte(8'hC3, a2);
        i2c_stop();
        check_eq("t7_recover_acks", {29'd0, a0, a1, a2}, 32'h7);
        check_eq("t7_recover_regs", regs, 32'h0000_00C3);

        check_eq("stb_width", stb_double, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/i2c_seg_target.md
# i2c_seg_target

I2C target (slave) receiver that models the seven-segment driver on the display bus of the ALU board. It samples SCL/SDA with the 100 MHz system clock, decodes write transactions addressed to its device address, and stores the bytes in a small register file that mirrors the digit registers. It acknowledges matching bytes by pulling SDA low. It is used as the bus-end counterpart to the display I2C master, both in the simulation bench and as an on-chip loopback monitor.

## Interface
Parameters:
- DEV_ADDR, 7'h70, 7-bit device address this target answers to.
- NUM_REGS, 4, number of data registers. Valid pointer range is 0..NUM_REGS-1.
- REG_WIDTH, 8, width of each data register. The byte width is fixed at 8, so only REG_WIDTH=8 is supported.

Ports:
- clk_i  in  1  system clock (100 MHz).
- reset_ni  in  1  reset, synchronous, active-low.
- scl_i  in  1  SCL line level, asynchronous.
- sda_i  in  1  SDA line level, asynchronous.
- sda_oe_o  out  1  1 = drive SDA low (ACK); 0 = release the line. Open-drain is handled at top level.
- regs_o  out  NUM_REGS x REG_WIDTH  register file contents.
- wr_stb_o  out  1  one-cycle pulse when a data byte is committed.
- wr_addr_o  out  $clog2(NUM_REGS)  index of the register written. Valid while wr_stb_o is high.
- busy_o  out  1  high from a START that this block detects until the following STOP.

## Operation
- Input conditioning: scl_i and sda_i each pass through a 2-FF synchronizer. A third register holds the previous value for edge detection.
- Bus events, evaluated on the synchronized signals:
  - START: SDA falls while SCL is high.
  - STOP: SDA rises while SCL is high.
  - Bit sample: on each SCL rising edge, the SDA value is shifted in MSB first.
- A 4-bit bit counter runs from 0 to 8 within each byte frame.
- FSM states:
  - IDLE: wait for START.
  - ADDR: shift 8 bits. Then:
    - If the upper 7 bits equal DEV_ADDR and the R/W bit is 0, go to ADDR_ACK.
    - Otherwise go to IGNORE. Reads are not supported and are NACKed.
  - ADDR_ACK: ACK, then go to PTR.
  - PTR: shift 8 bits. Then:
    - If the value is less than NUM_REGS, load the pointer and go to PTR_ACK.
    - Otherwise go to IGNORE (NACK).
  - PTR_ACK: ACK, then go to DATA.
  - DATA: shift 8 bits. On the 8th sample edge:
    - write the byte to regs[ptr];
    - pulse wr_stb_o with wr_addr_o = ptr;
    - set ptr = (ptr + 1) mod NUM_REGS (wraps from NUM_REGS-1 to 0);
    - go to DATA_ACK.
  - DATA_ACK: ACK, then go to DATA.
  - IGNORE: sda_oe_o stays 0 and no register writes occur until START or STOP.
- ACK timing:
  - sda_oe_o asserts on the first SCL falling edge after the 8th bit is sampled.
  - It deasserts on the next SCL falling edge, i.e. after the 9th clock.
- Events that take priority in any state:
  - START (including a repeated START): clear the bit counter, release SDA, go to ADDR.
  - STOP: release SDA, go to IDLE.
- A partial byte interrupted by START or STOP is discarded. No write occurs.
- The register file holds its values across transactions. Only reset clears it.

## Timing
- Reset (synchronous, reset_ni=0 at a clk_i edge) sets:
  - state IDLE, sda_oe_o=0, regs_o all 0, wr_stb_o=0, wr_addr_o=0, busy_o=0;
  - ptr=0, bit counter=0;
  - synchronizer stages preset to 1 (idle bus).
- Reset asserted mid-transfer aborts the transfer immediately. The block stays in IDLE until a fresh START.
- Latency from a pin edge to the internal event flag is 3 clk_i cycles (2 sync stages + edge register).
- regs_o and wr_stb_o update in the same cycle, 3 cycles after the SCL rising edge of the 8th data bit.
- sda_oe_o changes 4 cycles after the qualifying SCL falling edge: 3 for detection + 1 for the output register.
- Bus requirement: SCL high and low phases are each at least 8 clk_i cycles, and SDA is stable at least 4 cycles around each SCL rising edge. Standard and fast mode at 100 MHz meet this.
- wr_stb_o is exactly one cycle wide. There is at most one pulse per received data byte.

## Test plan
- Write address byte 0xE0, pointer 0x01, data 0x3F then 0x06, then STOP:
  - ACK on all four 9th clocks;
  - regs[1]=0x3F and regs[2]=0x06;
  - two wr_stb_o pulses, with wr_addr_o 1 then 2;
  - busy_o falls after the STOP.
- Address byte 0xE4 (wrong address) followed by data 0x55:
  - sda_oe_o never asserts;
  - regs unchanged, no wr_stb_o.
- Address byte 0xE1 (read request): NACK, state goes to IGNORE, and the target recovers on the next START to accept a valid write.
- Pointer 0x03 with data 0x11, 0x22, 0x33: regs[3]=0x11, regs[0]=0x22, regs[1]=0x33 (pointer wrap).
- Pointer 0x07 (out of range): NACK on the pointer byte and no writes for the following bytes.
- Boundary cases:
  - Repeated START after 4 bits of a data byte, then write 0xE0/0x00/0xAA: partial byte discarded, regs[0]=0xAA.
  - reset_ni pulsed low during a DATA_ACK phase: sda_oe_o=0 and all regs=0 on the next cycle.
